cv32e40p_tmr_fault_manager: RTL and testbench

//  Consumes the per-replica error flags of a TMR majority voter and manages fault recovery.

---
 rtl/cv32e40p_tmr_fault_manager.sv | 184 ++++++++++++++++++
 tb/tb_cv32e40p_tmr_fault_manager.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_tmr_fault_manager.sv
// Fault manager beside a TMR voter: classifies votes, drives replica resync,
// disables a persistently failing replica and escalates to a sticky fatal state.
module cv32e40p_tmr_fault_manager #(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CLEAN_WIN = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             err_detected_1_i,
  input  logic             err_detected_2_i,
  input  logic             err_detected_3_i,
  input  logic             err_corrected_i,
  output logic             resync_req_o,
  output logic [1:0]       resync_id_o,
  input  logic             resync_ack_i,
  output logic [2:0]       replica_dis_o,
  output logic [1:0]       state_o,
  output logic             fatal_o,
  output logic [CNT_W-1:0] err_cnt_1_o,
  output logic [CNT_W-1:0] err_cnt_2_o,
  output logic [CNT_W-1:0] err_cnt_3_o
);

  localparam int unsigned RW = $clog2(RETRY_MAX + 2);
  localparam int unsigned CW = $clog2(CLEAN_WIN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(RETRY_MAX);
  localparam logic [CW-1:0] CLEAN_LAST = CW'(CLEAN_WIN - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_RESYNC   = 2'b01,
    ST_DEGRADED = 2'b10,
    ST_FAIL     = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic             req_q, req_d;
  logic [1:0]       id_q, id_d;
  logic [2:0]       dis_q, dis_d;
  logic             fatal_q, fatal_d;
  logic [CNT_W-1:0] cnt_q   [3];
  logic [CNT_W-1:0] cnt_d   [3];
  logic [RW-1:0]    retry_q [3];
  logic [RW-1:0]    retry_d [3];
  logic [CW-1:0]    clean_q, clean_d;
  logic [TW-1:0]    tmo_q, tmo_d;

  logic [2:0] flags, single_vec, id_oh, dis_req;
  logic       onehot, single, clean, uncorr, go_fail;

  // Any non-empty flag pattern that is not a corrected single error is uncorrectable.
  assign flags      = {err_detected_3_i, err_detected_2_i, err_detected_1_i};
  assign onehot     = (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
  assign single     = valid_i && err_corrected_i && onehot;
  assign single_vec = single ? flags : 3'b000;
  assign clean      = valid_i && (flags == 3'b000);
  assign uncorr     = valid_i && !clean && !single;
  assign id_oh      = {id_q == 2'd3, id_q == 2'd2, id_q == 2'd1};

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    dis_d   = dis_q;
    fatal_d = fatal_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    clean_d = clean_q;
    tmo_d   = tmo_q;
    go_fail = 1'b0;
    dis_req = 3'b000;

    if (state_q != ST_FAIL) begin
      for (int unsigned k = 0; k < 3; k++) begin
        if (single_vec[k] && (cnt_q[k] != '1)) cnt_d[k] = cnt_q[k] + 1'b1;
      end
      if (valid_i && !clean) clean_d = '0;
    end

    unique case (state_q)
      ST_NORMAL: begin
        if (uncorr) begin
          go_fail = 1'b1;
        end else if (single) begin
          for (int unsigned k = 0; k < 3; k++) begin
            if (single_vec[k]) begin
              retry_d[k] = retry_q[k] + 1'b1;
              if (retry_d[k] > RETRY_LIM) begin
                dis_req[k] = 1'b1;
              end else begin
                req_d   = 1'b1;
                id_d    = 2'(k + 1);
                tmo_d   = '0;
                state_d = ST_RESYNC;
              end
            end
          end
        end else if (clean) begin
          if (clean_q == CLEAN_LAST) begin
            clean_d = '0;
            retry_d = '{default: '0};
          end else begin
            clean_d = clean_q + 1'b1;
          end
        end
      end
      ST_RESYNC: begin
        if (uncorr || |(single_vec & ~id_oh)) begin
          go_fail = 1'b1;
        end else if (resync_ack_i) begin
          req_d   = 1'b0;
          id_d    = 2'd0;
          state_d = ST_NORMAL;
        end else if (tmo_q == TMO_LAST) begin
          dis_req = id_oh;
          req_d   = 1'b0;
          id_d    = 2'd0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_DEGRADED: begin
        if (uncorr || |(single_vec & ~dis_q)) go_fail = 1'b1;
      end
      default: ;
    endcase

    // A second disable can never be honoured; it escalates instead.
    if (|dis_req) begin
      if (|dis_q) begin
        go_fail = 1'b1;
      end else begin
        dis_d   = dis_req;
        state_d = ST_DEGRADED;
      end
    end

    if (go_fail) begin
      state_d = ST_FAIL;
      fatal_d = 1'b1;
      req_d   = 1'b0;
      id_d    = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_NORMAL;
      req_q   <= 1'b0;
      id_q    <= 2'd0;
      dis_q   <= '0;
      fatal_q <= 1'b0;
      cnt_q   <= '{default: '0};
      retry_q <= '{default: '0};
      clean_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      id_q    <= id_d;
      dis_q   <= dis_d;
      fatal_q <= fatal_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      clean_q <= clean_d;
      tmo_q   <= tmo_d;
    end
  end

  assign resync_req_o  = req_q;
  assign resync_id_o   = id_q;
  assign replica_dis_o = dis_q;
  assign state_o       = state_q;
  assign fatal_o       = fatal_q;
  assign err_cnt_1_o   = cnt_q[0];
  assign err_cnt_2_o   = cnt_q[1];
  assign err_cnt_3_o   = cnt_q[2];

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Bench for cv32e40p_tmr_fault_manager: directed scenarios plus random votes
// checked against a behavioural model of the fault-recovery rules.
module tb_cv32e40p_tmr_fault_manager;
  localparam int CNT_W     = 8;
  localparam int RETRY_MAX = 3;
  localparam int TIMEOUT   = 64;
  localparam int CLEAN_WIN = 256;
  localparam int CMAX      = (1 << CNT_W) - 1;
  localparam int VW        = 9 + 3 * CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid_i = 1'b0, e1 = 1'b0, e2 = 1'b0, e3 = 1'b0, corr = 1'b0, ack = 1'b0;
  logic resync_req_o, fatal_o;
  logic [1:0] resync_id_o, state_o;
  logic [2:0] replica_dis_o;
  logic [CNT_W-1:0] err_cnt_1_o, err_cnt_2_o, err_cnt_3_o;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_state, m_id, m_clean, m_tmo;
  bit m_req, m_fatal;
  bit [2:0] m_dis;
  int m_cnt[3];
  int m_retry[3];

  cv32e40p_tmr_fault_manager #(
    .CNT_W(CNT_W), .RETRY_MAX(RETRY_MAX), .TIMEOUT(TIMEOUT), .CLEAN_WIN(CLEAN_WIN)
  ) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i),
    .err_detected_1_i(e1), .err_detected_2_i(e2), .err_detected_3_i(e3),
    .err_corrected_i(corr), .resync_req_o(resync_req_o), .resync_id_o(resync_id_o),
    .resync_ack_i(ack), .replica_dis_o(replica_dis_o), .state_o(state_o),
    .fatal_o(fatal_o), .err_cnt_1_o(err_cnt_1_o), .err_cnt_2_o(err_cnt_2_o),
    .err_cnt_3_o(err_cnt_3_o)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] obs();
    return {state_o, fatal_o, resync_req_o, resync_id_o, replica_dis_o,
            err_cnt_3_o, err_cnt_2_o, err_cnt_1_o};
  endfunction

  function automatic logic [VW-1:0] expv();
    return {2'(m_state), m_fatal, m_req, 2'(m_id), m_dis,
            CNT_W'(m_cnt[2]), CNT_W'(m_cnt[1]), CNT_W'(m_cnt[0])};
  endfunction

  task automatic fail_model();
    m_state = 3; m_fatal = 1; m_req = 0; m_id = 0;
  endtask

  task automatic disable_model(input int k);
    if (m_dis != 3'b000) fail_model();
    else begin m_dis[k] = 1'b1; m_state = 2; end
  endtask

  task automatic model_update(input bit v, input bit [2:0] f, input bit c,
                              input bit a, input bit r);
    int n, k;
    bit sgl, unc, cln;
    if (r) begin
      m_state = 0; m_fatal = 0; m_req = 0; m_id = 0; m_dis = 0;
      m_clean = 0; m_tmo = 0;
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_retry[i] = 0; end
      return;
    end
    if (m_state == 3) return;
    n = $countones(f);
    k = 0;
    for (int i = 0; i < 3; i++) if (f[i]) k = i;
    sgl = v && n == 1 && c;
    unc = v && n != 0 && !sgl;
    cln = v && n == 0;
    if (sgl && m_cnt[k] < CMAX) m_cnt[k]++;
    if (unc || sgl) m_clean = 0;
    case (m_state)
      0: begin
        if (unc) fail_model();
        else if (sgl) begin
          m_retry[k]++;
          if (m_retry[k] > RETRY_MAX) disable_model(k);
          else begin m_req = 1; m_id = k + 1; m_tmo = 0; m_state = 1; end
        end else if (cln) begin
          m_clean++;
          if (m_clean == CLEAN_WIN) begin
            m_clean = 0;
            for (int i = 0; i < 3; i++) m_retry[i] = 0;
          end
        end
      end
      1: begin
        if (unc || (sgl && k + 1 != m_id)) fail_model();
        else if (a) begin m_req = 0; m_id = 0; m_state = 0; end
        else begin
          m_tmo++;
          if (m_tmo == TIMEOUT) begin
            int d;
            d = m_id - 1;
            m_req = 0; m_id = 0;
            disable_model(d);
          end
        end
      end
      2: if (unc || (sgl && !m_dis[k])) fail_model();
      default: ;
    endcase
  endtask

  task automatic step(input bit v, input bit [2:0] f, input bit c,
                      input bit a, input bit r);
    valid_i = v; e1 = f[0]; e2 = f[1]; e3 = f[2]; corr = c; ack = a; rst = r;
    @(posedge clk);
    model_update(v, f, c, a, r);
    #1;
  endtask

  task automatic test_reset();
    step(1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    checks++;
    if (obs() !== '0) begin
      failures++; $display("FAIL reset_state got=%h want=0", obs());
    end
  endtask

  task automatic test_clean();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 3'b000, 1'b0, 1'($urandom), 1'b0);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL clean_run[%0d] got=%h want=%h", i, obs(), expv());
      end
    end
    checks++;
    if (state_o !== 2'b00 || fatal_o !== 1'b0 || err_cnt_1_o !== '0) begin
      failures++; $display("FAIL clean_final got=%h want=0", obs());
    end
  endtask

  task automatic test_single_resync();
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({resync_req_o, resync_id_o, state_o} !== {1'b1, 2'd2, 2'b01}) begin
      failures++; $display("FAIL t2_req got=%b%b%b want=1 10 01", resync_req_o, resync_id_o, state_o);
    end
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (resync_req_o !== 1'b1 || resync_id_o !== 2'd2) begin
      failures++; $display("FAIL t2_hold got=%b%b want=1 10", resync_req_o, resync_id_o);
    end
    step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({state_o, resync_req_o, resync_id_o, err_cnt_2_o} !== {2'b00, 1'b0, 2'd0, 8'd1}) begin
      failures++; $display("FAIL t2_ack got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_disable();
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
      if (i < 3) step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if ({replica_dis_o, state_o, resync_req_o, err_cnt_3_o} !== {3'b100, 2'b10, 1'b0, 8'd4}) begin
      failures++; $display("FAIL t3_disable got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_fail_with_ack();
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({state_o, fatal_o, resync_req_o} !== {2'b11, 1'b1, 1'b0}) begin
      failures++; $display("FAIL t4_fail got=%h want=%h", obs(), expv());
    end
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'b11 || fatal_o !== 1'b1) begin
      failures++; $display("FAIL t4_sticky got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_timeout();
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'b01 || resync_req_o !== 1'b1) begin
      failures++; $display("FAIL t5_before_tmo got=%h want=%h", obs(), expv());
    end
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({replica_dis_o, state_o, resync_req_o} !== {3'b010, 2'b10, 1'b0}) begin
      failures++; $display("FAIL t5_tmo got=%h want=%h", obs(), expv());
    end
    step(1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'b10) begin
      failures++; $display("FAIL t5_ignore_dis got=%h want=%h", obs(), expv());
    end
    step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
    checks++;
    if (state_o !== 2'b11 || fatal_o !== 1'b1) begin
      failures++; $display("FAIL t5_fail got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_reset_and_saturate();
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 3'b100, 1'b1, 1'b0, 1'b0);
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs() !== '0) begin
      failures++; $display("FAIL t6_mid_reset got=%h want=0", obs());
    end
    for (int i = 0; i < 260; i++) begin
      step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
      if (m_state == 1) step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (err_cnt_1_o !== 8'd255 || obs() !== expv()) begin
      failures++; $display("FAIL t6_saturate got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_clean_window();
    for (int w = CLEAN_WIN - 1; w <= CLEAN_WIN; w++) begin
      step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < RETRY_MAX; i++) begin
        step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
      end
      for (int i = 0; i < w; i++) step(1'b1, 3'b000, 1'($urandom), 1'b0, 1'b0);
      step(1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
      checks++;
      if (state_o !== ((w == CLEAN_WIN) ? 2'b01 : 2'b10) || obs() !== expv()) begin
        failures++; $display("FAIL clean_win_%0d got=%h want=%h", w, obs(), expv());
      end
    end
  endtask

  task automatic test_random();
    bit v, c, a, r;
    bit [2:0] f;
    int p;
    step(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      p = $urandom_range(0, 99);
      v = 1'b1; c = 1'($urandom); f = 3'b000;
      if (p < 60) f = 3'b000;
      else if (p < 78) begin f = 3'b001 << $urandom_range(0, 2); c = 1'b1; end
      else if (p < 81) f = 3'($urandom_range(1, 7));
      else begin v = 1'b0; f = 3'($urandom); end
      a = ($urandom_range(0, 99) < 30);
      r = (m_state >= 2) && ($urandom_range(0, 99) < 8);
      step(v, f, c, a, r);
      checks++;
      if (obs() !== expv()) begin
        failures++; $display("FAIL random[%0d] got=%h want=%h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_resync();
    test_disable();
    test_fail_with_ack();
    test_timeout();
    test_reset_and_saturate();
    test_clean_window();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
